// File: rtl/regfile32_dump.sv
// 32 x 32-bit CPU register file (x0 hardwired to zero) with two bypassed combinational
// read ports and a valid/ready debug dump engine that streams every register out in order.
module regfile32_dump #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b,
    input  logic              i_dump_start,
    output logic              o_dump_busy,
    output logic              o_dump_valid,
    input  logic              i_dump_ready,
    output logic [ADDR_W-1:0] o_dump_idx,
    output logic [DATA_W-1:0] o_dump_data,
    output logic              o_dump_done
);

    localparam int unsigned       DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    logic [DATA_W-1:0] r_regs [DEPTH];
    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_data_nxt;

    logic              w_wr_en;
    logic              w_hit_a;
    logic              w_hit_b;
    logic              w_hit_n;
    logic [ADDR_W-1:0] w_nidx;
    logic [DATA_W-1:0] w_ndata;

    assign w_wr_en = i_we && (i_waddr != '0);
    assign w_hit_a = w_wr_en && (i_waddr == i_raddr_a);
    assign w_hit_b = w_wr_en && (i_waddr == i_raddr_b);

    assign o_rdata_a = (i_raddr_a == '0) ? '0 : (w_hit_a ? i_wdata : r_regs[i_raddr_a]);
    assign o_rdata_b = (i_raddr_b == '0) ? '0 : (w_hit_b ? i_wdata : r_regs[i_raddr_b]);

    // Third internal read port feeding the dump: next beat sees a same-cycle write.
    assign w_nidx  = r_idx + ADDR_W'(1);
    assign w_hit_n = w_wr_en && (i_waddr == w_nidx);
    assign w_ndata = (w_nidx == '0) ? '0 : (w_hit_n ? i_wdata : r_regs[w_nidx]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        case (r_state)
            StIdle: begin
                if (i_dump_start) begin
                    w_state_nxt = StRun;
                    w_idx_nxt   = '0;
                    w_data_nxt  = '0;
                end
            end
            StRun: begin
                if (i_dump_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = StDone;
                        w_data_nxt  = '0;
                    end else begin
                        w_idx_nxt  = w_nidx;
                        w_data_nxt = w_ndata;
                    end
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
                w_idx_nxt   = '0;
                w_data_nxt  = '0;
            end
            default: begin
                w_state_nxt = StIdle;
                w_idx_nxt   = '0;
                w_data_nxt  = '0;
            end
        endcase
    end

    assign o_dump_busy  = (r_state != StIdle);
    assign o_dump_valid = (r_state == StRun);
    assign o_dump_done  = (r_state == StDone);
    assign o_dump_idx   = r_idx;
    assign o_dump_data  = r_data;

endmodule

// File: tb/tb_regfile32_dump.sv
// Bench for regfile32_dump: table-driven read/write vectors plus scoreboarded dump sequences.
module tb_regfile32_dump;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr_a;
    logic [31:0] rdata_a;
    logic [4:0]  raddr_b;
    logic [31:0] rdata_b;
    logic        start;
    logic        busy;
    logic        valid;
    logic        ready;
    logic [4:0]  idx;
    logic [31:0] data;
    logic        done;

    regfile32_dump #(
        .DATA_W(32),
        .ADDR_W(5)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_we        (we),
        .i_waddr     (waddr),
        .i_wdata     (wdata),
        .i_raddr_a   (raddr_a),
        .o_rdata_a   (rdata_a),
        .i_raddr_b   (raddr_b),
        .o_rdata_b   (rdata_b),
        .i_dump_start(start),
        .o_dump_busy (busy),
        .o_dump_valid(valid),
        .i_dump_ready(ready),
        .o_dump_idx  (idx),
        .o_dump_data (data),
        .o_dump_done (done)
    );

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } beat_t;

    int          checks;
    int          errors;
    int          busy_cnt;
    int          done_cnt;
    int          beat_cnt;
    beat_t       exp_q[$];
    logic [31:0] m_regs[32];
    vec_t        vecs[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t required finish earlier", $time);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    // Stream monitor: every accepted beat is popped from the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                chk("done_valid_low", {31'd0, valid}, 32'd0);
                chk("done_busy_high", {31'd0, busy}, 32'd1);
                chk("done_after_beat31", beat_cnt, 32);
            end
            if (valid && ready) begin
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected actual_idx=%0d required=no beat", idx);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk("beat_idx", {27'd0, idx}, {27'd0, b.idx});
                    chk("beat_data", data, b.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected();
        for (int i = 0; i < 32; i++) begin
            beat_t b;
            b.idx  = 5'(i);
            b.data = m_regs[i];
            exp_q.push_back(b);
        end
    endtask

    // mode 0: ready held high; 1: ready 1-0-0-1 with writes around beat 3; 2: restart at idx 10
    task automatic run_dump(input int mode);
        int   c;
        logic w3done;
        logic restarted;
        w3done    = 1'b0;
        restarted = 1'b0;
        busy_cnt  = 0;
        done_cnt  = 0;
        beat_cnt  = 0;
        push_expected();
        if (mode == 1) begin
            exp_q[4].data = 32'hBBBB0000;
            m_regs[3]     = 32'hAAAA0000;
            m_regs[4]     = 32'hBBBB0000;
        end
        ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        c = 0;
        while (busy && c < 300) begin
            we    = 1'b0;
            start = 1'b0;
            ready = 1'b1;
            if (mode == 1) begin
                ready = (c % 4 == 0) || (c % 4 == 3);
                if (idx == 5'd3 && !ready && w3done)
                    chk("stall_hold_data", data, 32'h03030303);
                if (idx == 5'd3 && !ready && !w3done) begin
                    we = 1'b1; waddr = 5'd3; wdata = 32'hAAAA0000; w3done = 1'b1;
                end
                if (idx == 5'd3 && ready) begin
                    we = 1'b1; waddr = 5'd4; wdata = 32'hBBBB0000;
                end
            end else if (mode == 2) begin
                if (idx == 5'd10 && !restarted) begin
                    start = 1'b1; restarted = 1'b1;
                end
            end
            step();
            c++;
        end
        we    = 1'b0;
        start = 1'b0;
        ready = 1'b1;
        if (c >= 300) begin
            checks++;
            errors++;
            $display("FAIL dump_timeout cycles=%0d required=busy drop", c);
        end
        chk("dump_beats", beat_cnt, 32);
        chk("dump_done_pulses", done_cnt, 1);
        chk("dump_queue_empty", exp_q.size(), 0);
        if (mode != 1) chk("dump_busy_cycles", busy_cnt, 33);
        chk("idle_idx", {27'd0, idx}, 32'd0);
        chk("idle_valid", {31'd0, valid}, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);
    endtask

    task automatic read_all_zero(input string nm);
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i);
            raddr_b = 5'(31 - i);
            #1;
            chk({nm, "_a"}, rdata_a, 32'd0);
            chk({nm, "_b"}, rdata_b, 32'd0);
        end
    endtask

    initial begin
        int c;
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        raddr_a = '0;
        raddr_b = '0;
        start   = 1'b0;
        ready   = 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;

        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd0,  5'd1, 32'h0,        32'h0};
        vecs[1] = '{1'b0, 5'd0, 32'h0,        5'd5,  5'd0, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0,  5'd5, 32'h0,        32'hDEADBEEF};
        vecs[3] = '{1'b0, 5'd0, 32'h0,        5'd0,  5'd0, 32'h0,        32'h0};
        vecs[4] = '{1'b1, 5'd7, 32'h12345678, 5'd5,  5'd7, 32'hDEADBEEF, 32'h12345678};
        vecs[5] = '{1'b0, 5'd0, 32'h0,        5'd7,  5'd7, 32'h12345678, 32'h12345678};
        vecs[6] = '{1'b1, 5'd7, 32'hCAFEF00D, 5'd7,  5'd7, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[7] = '{1'b0, 5'd0, 32'h0,        5'd31, 5'd1, 32'h0,        32'h0};

        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_idx", {27'd0, idx}, 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        #10;
        rst_n = 1'b1;
        step();
        read_all_zero("rst_read");

        for (int i = 0; i < 8; i++) begin
            we      = vecs[i].we;
            waddr   = vecs[i].waddr;
            wdata   = vecs[i].wdata;
            raddr_a = vecs[i].ra;
            raddr_b = vecs[i].rb;
            @(negedge clk);
            chk($sformatf("vec%0d_a", i), rdata_a, vecs[i].ea);
            chk($sformatf("vec%0d_b", i), rdata_b, vecs[i].eb);
            step();
        end
        we = 1'b0;

        for (int i = 1; i < 32; i++) begin
            we        = 1'b1;
            waddr     = 5'(i);
            wdata     = 32'(i) * 32'h01010101;
            m_regs[i] = 32'(i) * 32'h01010101;
            step();
        end
        we = 1'b0;

        run_dump(0);
        run_dump(1);
        raddr_a = 5'd3;
        raddr_b = 5'd4;
        #1;
        chk("post_dump_x3", rdata_a, 32'hAAAA0000);
        chk("post_dump_x4", rdata_b, 32'hBBBB0000);
        run_dump(2);

        // Asynchronous reset in the middle of a dump.
        busy_cnt = 0;
        done_cnt = 0;
        beat_cnt = 0;
        push_expected();
        ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        c = 0;
        while (idx != 5'd15 && c < 100) begin
            step();
            c++;
        end
        if (c >= 100) begin
            checks++;
            errors++;
            $display("FAIL reach_idx15 cycles=%0d required idx=15", c);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", {31'd0, valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_data", data, 32'd0);
        chk("abort_idx", {27'd0, idx}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_beats", beat_cnt, 15);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        for (int i = 0; i < 4; i++) step();
        chk("abort_no_done", done_cnt, 0);
        chk("abort_idle", {31'd0, busy}, 32'd0);
        read_all_zero("abort_read");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile32_dump.md
Name: regfile32_dump

Overview:
- 32-entry × 32-bit CPU register file for the cpu32 datapath.
- One synchronous write port and two combinational read ports. x0 is hardwired to zero.
- Includes a debug dump engine that reads every register out over a valid/ready stream. The dump is the readback side of the register write path; the debug/trace unit consumes it.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width. Depth is 2**ADDR_W (32).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  reset: one clock, asynchronous, active-low.
- WE  in  1  write enable.
- WADDR  in  ADDR_W  write index.
- WDATA  in  DATA_W  write data.
- RADDR_A  in  ADDR_W  read port A index.
- RDATA_A  out  DATA_W  read port A data (combinational).
- RADDR_B  in  ADDR_W  read port B index.
- RDATA_B  out  DATA_W  read port B data (combinational).
- DUMP_START  in  1  single-cycle request to start a dump.
- DUMP_BUSY  out  1  dump in progress.
- DUMP_VALID  out  1  dump beat valid.
- DUMP_READY  in  1  consumer accepts beat.
- DUMP_IDX  out  ADDR_W  index of the current beat.
- DUMP_DATA  out  DATA_W  register value of the current beat.
- DUMP_DONE  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (RST_N=0, async): all 32 registers clear to 0; FSM goes to IDLE.
  - Reset values: DUMP_BUSY=0, DUMP_VALID=0, DUMP_IDX=0, DUMP_DATA=0, DUMP_DONE=0.
  - Reset during a dump aborts it; no DONE pulse.
- Write: on a rising edge with WE=1 and WADDR!=0, the register at WADDR takes WDATA. Writes to index 0 are discarded.
- Read: RDATA_x = 0 when RADDR_x==0. Otherwise it is the stored value, with write-through bypass:
  - If WE=1 and WADDR==RADDR_x and WADDR!=0 in the same cycle, RDATA_x=WDATA.
  - Zero-cycle read latency.
- Dump FSM states: IDLE, RUN, DONE.
  - IDLE: DUMP_START=1 → RUN. Next cycle: DUMP_VALID=1, DUMP_IDX=0, DUMP_DATA=0, DUMP_BUSY=1.
  - RUN, handshake (VALID&READY) with IDX<31: next cycle IDX=IDX+1. DUMP_DATA is loaded from reg[IDX+1] as seen at the handshake edge, including bypass of a same-cycle write to IDX+1. VALID stays 1.
  - RUN, VALID=1 & READY=0: IDX and DATA hold stable. Later writes to that index do not change the held DUMP_DATA.
  - RUN, handshake at IDX=31 → DONE. Next cycle: VALID=0, DUMP_DONE=1 for exactly one cycle, BUSY=1.
  - DONE → IDLE unconditionally the following cycle: BUSY=0, DONE=0, IDX returns to 0.
  - DUMP_START outside IDLE is ignored; no queuing.
- Normal read and write ports stay fully functional during a dump. The dump never stalls or blocks writes.
- Dump length is always 32 beats. Minimum duration with READY held at 1 is 1 + 32 + 1 cycles from START to return to IDLE.

Test Plan:
- Reset, then read all 32 indices on both ports → all 0. Write x5=0xDEADBEEF, next cycle RADDR_A=5 → 0xDEADBEEF.
- WE=1, WADDR=0, WDATA=0xFFFFFFFF; then RADDR_A=0 → 0. Same-cycle WE=1, WADDR=7, WDATA=0x12345678 with RADDR_B=7 → RDATA_B=0x12345678 in that cycle.
- Preload xi=i*0x01010101 for i=1..31; pulse START with READY=1 → 32 consecutive beats with IDX 0..31 and DATA 0, 0x01010101, …, 0x1F1F1F1F. DONE pulses once on the cycle after beat 31, then BUSY=0.
- Dump with READY toggling 1-0-0-1 → no beat skipped or duplicated.
  - While stalled on IDX=3, write x3=0xAAAA0000 → DUMP_DATA stays 0x03030303.
  - Write x4=0xBBBB0000 in the cycle beat 3 is accepted → beat 4 DATA=0xBBBB0000.
- Pulse START again while mid-dump at IDX=10 → the dump continues unaffected. Exactly 32 beats and one DONE in total.
- Assert RST_N=0 asynchronously mid-cycle at IDX=15 → VALID, BUSY and DATA go to 0 immediately, with no DONE pulse. All registers read 0 after reset.
